// File: rtl/uart_tx_periph_if.sv
// Data-bus view of the UART transmitter: MEM-stage address/store data/strobes
// going in, decode hit and load data coming back.
interface uart_tx_periph_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic        hit;
    logic [31:0] rdata;

    modport master (
        output addr, wdata, mem_write, mem_read,
        input  hit, rdata
    );

    modport slave (
        input  addr, wdata, mem_write, mem_read,
        output hit, rdata
    );
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores fill a small FIFO that an
// FSM drains LSB first onto tx; STATUS reports FIFO fill, overflow and busy.
module uart_tx_periph #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h40000020
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_periph_if.slave bus,
    output logic            tx,
    output logic            tx_busy
);
    localparam int              AW          = $clog2(FIFO_DEPTH);
    localparam int              CW          = $clog2(CLKS_PER_BIT);
    localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [AW:0]     DEPTH_C     = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]   BAUD_LAST   = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    state_t        r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic          w_sel_tx;
    logic          w_sel_st;
    logic          w_wr_tx;
    logic          w_wr_st;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_baud_done;
    logic [31:0]   w_status;
    logic          w_unused;

    // Word-aligned decode: the byte offset within the word is ignored.
    assign w_sel_tx    = (bus.addr[31:2] == BASE_ADDR[31:2]);
    assign w_sel_st    = (bus.addr[31:2] == STATUS_ADDR[31:2]);
    assign w_wr_tx     = bus.mem_write && w_sel_tx;
    assign w_wr_st     = bus.mem_write && w_sel_st;
    assign w_full      = (r_count == DEPTH_C);
    assign w_empty     = (r_count == '0);
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign w_push      = w_wr_tx && (!w_full || w_pop);
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_unused    = ^{bus.wdata[31:8], bus.addr[1:0]};

    assign tx_busy   = (r_state != S_IDLE) || !w_empty;
    assign tx        = r_tx;
    assign w_status  = {24'b0, 4'(r_count), r_ovf, tx_busy, w_empty, w_full};
    assign bus.hit   = w_sel_tx || w_sel_st;
    assign bus.rdata = (w_sel_st && bus.mem_read) ? w_status : 32'b0;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
            // A store into a full FIFO is only lost when the FSM is not popping this cycle.
            if (w_wr_tx && w_full && !w_pop)      r_ovf <= 1'b1;
            else if (w_wr_st && bus.wdata[3])     r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboarded bench for uart_tx_periph: a queue-level model predicts accepted
// bytes and frame start cycles; a line monitor decodes tx and checks them.
module tb_uart_tx_periph;
    localparam int          C    = 4;
    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'h40000020;
    localparam logic [31:0] STAT = 32'h40000024;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx;
    logic tx_busy;

    uart_tx_periph_if bus();

    uart_tx_periph #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .bus(bus), .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: pending bytes, transmitter-busy countdown, sticky overflow.
    typedef struct {logic [7:0] b; int c;} exp_t;
    logic [7:0] m_fifo[$];
    exp_t       exp_q[$];
    int         free_cnt = 0;
    logic       m_ovf = 1'b0;
    int         cyc = 0;

    function automatic logic m_busy();
        return (free_cnt > 0) || (m_fifo.size() > 0);
    endfunction

    function automatic logic [31:0] exp_status();
        int n = m_fifo.size();
        return {24'b0, 4'(n), m_ovf, m_busy(), (n == 0), (n == D)};
    endfunction

    always @(posedge clk) begin : model
        logic pop, full, wr_tx, wr_st;
        exp_t e;
        cyc++;
        if (!reset) begin
            m_fifo.delete();
            exp_q.delete();
            free_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            pop   = (free_cnt == 0) && (m_fifo.size() > 0);
            full  = (m_fifo.size() == D);
            wr_tx = bus.mem_write && (bus.addr[31:2] == BASE[31:2]);
            wr_st = bus.mem_write && (bus.addr[31:2] == STAT[31:2]);
            if (free_cnt > 0) free_cnt--;
            if (pop) begin
                e.b = m_fifo.pop_front();
                e.c = cyc;
                exp_q.push_back(e);
                free_cnt = 10 * C;
            end
            if (wr_tx) begin
                if (!full || pop) m_fifo.push_back(bus.wdata[7:0]);
                else m_ovf = 1'b1;
            end
            if (wr_st && bus.wdata[3]) m_ovf = 1'b0;
        end
    end

    // Line monitor: decodes each frame sample-by-sample and scores it.
    bit         mon_act = 1'b0;
    int         mon_k = 0;
    int         mon_start = 0;
    int         mon_err = 0;
    logic [7:0] mon_bits = '0;

    always @(negedge clk) begin : monitor
        int slot, phase;
        exp_t e;
        if (!reset) begin
            mon_act = 1'b0;
        end else begin
            check("tx_busy", tx_busy, m_busy());
            if (!mon_act && tx !== 1'b1) begin
                mon_act = 1'b1;
                mon_k = 0;
                mon_start = cyc;
                mon_err = 0;
                mon_bits = '0;
            end
            if (mon_act) begin
                slot  = mon_k / C;
                phase = mon_k % C;
                if (slot == 0) begin
                    if (tx !== 1'b0) mon_err++;
                end else if (slot <= 8) begin
                    if (phase == 0) mon_bits[slot-1] = tx;
                    else if (tx !== mon_bits[slot-1]) mon_err++;
                end else begin
                    if (tx !== 1'b1) mon_err++;
                end
                mon_k++;
                if (mon_k == 10 * C) begin
                    mon_act = 1'b0;
                    check("frame_shape", mon_err, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got byte %h expected no frame", mon_bits);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", mon_bits, e.b);
                        check("start_cycle", mon_start, e.c);
                    end
                end
            end
        end
    end

    task automatic bus_idle();
        bus.addr = '0;
        bus.wdata = '0;
        bus.mem_write = 1'b0;
        bus.mem_read = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.wdata = d;
        bus.mem_write = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk);
        #1 bus.mem_write = 1'b0;
    endtask

    task automatic read_status(input string name);
        @(negedge clk);
        bus.addr = STAT;
        bus.mem_read = 1'b1;
        bus.mem_write = 1'b0;
        #1;
        check(name, bus.rdata, exp_status());
        check("status_hit", bus.hit, 1);
        @(posedge clk);
        #1 bus.mem_read = 1'b0;
    endtask

    // Read and write STATUS in one cycle: rdata must show the pre-edge value.
    task automatic rw_status(input string name, input logic [31:0] d);
        @(negedge clk);
        bus.addr = STAT;
        bus.wdata = d;
        bus.mem_read = 1'b1;
        bus.mem_write = 1'b1;
        #1;
        check(name, bus.rdata, exp_status());
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (!(m_fifo.size() == 0 && free_cnt == 0 && exp_q.size() == 0 && !mon_act) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s: drain still pending after %0d cycles, required done", name, n);
        end
        @(negedge clk);
    endtask

    logic [31:0] nonhit [2] = '{32'h40000028, 32'h00000000};

    initial begin
        bus_idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        repeat (20) @(negedge clk);
        check("idle_tx", tx, 1);
        check("idle_busy", tx_busy, 0);
        bus.addr = STAT;
        bus.mem_read = 1'b1;
        #1 check("status_reset", bus.rdata, 32'h00000002);
        bus.mem_read = 1'b0;
        read_status("status_reset_model");

        store(BASE, 32'hFFFF_FFA5);
        read_status("status_single");
        wait_drain("drain_a5");
        check("post_frame_busy", tx_busy, 0);
        check("post_frame_tx", tx, 1);

        for (int i = 1; i <= 6; i++) store(BASE, i);
        read_status("status_overflow");
        wait_drain("drain_burst");

        rw_status("status_wr0_rd", 32'h0);
        read_status("status_ovf_kept");
        rw_status("status_clr_rd", 32'h8);
        read_status("status_ovf_cleared");

        store(BASE, 32'h3C);
        foreach (nonhit[j]) begin
            @(negedge clk);
            bus.addr = nonhit[j];
            bus.wdata = $urandom();
            bus.mem_read = 1'b1;
            bus.mem_write = 1'b1;
            #1;
            check("nonhit_hit", bus.hit, 0);
            check("nonhit_rdata", bus.rdata, 0);
            @(posedge clk);
            #1 bus_idle();
        end
        read_status("status_after_nonhit");
        wait_drain("drain_nonhit");

        for (int burst = 0; burst < 5; burst++) begin
            int n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                store(BASE | 32'($urandom_range(0, 3)), $urandom());
                if ($urandom_range(0, 3) == 0) read_status("status_random");
            end
            if ($urandom_range(0, 1) == 1) rw_status("status_random_clr", 32'h8);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_drain("drain_random");

        store(BASE, 32'h5A);
        store(BASE, 32'hC3);
        repeat (17) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_tx_high", tx, 1);
        check("reset_busy_low", tx_busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.addr = STAT;
        bus.mem_read = 1'b1;
        #1 check("status_after_reset", bus.rdata, 32'h00000002);
        bus.mem_read = 1'b0;
        begin
            int lows = 0;
            repeat (60) begin
                @(negedge clk);
                if (tx !== 1'b1) lows++;
            end
            check("tx_quiet_after_reset", lows, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end
endmodule
